vga_timing_monitor: RTL and testbench

- Receive-side counterpart of the VGA sync generator. Samples Hsync/Vsync/dena at pixel rate and recovers pixel coordinates.
- Checks every line and frame against the Ha..Vd timing parameters, runs a lock FSM, and reports errors and measured totals.
- Sits on the VGA bus beside the image generator. Used for on-chip self-check and as the bench's scoreboard front end.

---
 rtl/vga_timing_monitor.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel coordinates from a VGA sync stream,
// checks line/frame timing and tracks lock over whole frames.
module vga_timing_monitor #(
  parameter int   Ha            = 96,
  parameter int   Hb            = 144,
  parameter int   Hc            = 784,
  parameter int   Hd            = 800,
  parameter int   Va            = 2,
  parameter int   Vb            = 35,
  parameter int   Vc            = 515,
  parameter int   Vd            = 525,
  parameter logic SYNC_POL      = 1'b0,
  parameter int   LOCK_FRAMES   = 2,
  parameter int   UNLOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic        dena,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [10:0] h_total,
  output logic [10:0] v_total
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [10:0] CMAX  = 11'h7ff;
  localparam logic [10:0] HA_L  = 11'(Ha);
  localparam logic [10:0] HB_L  = 11'(Hb);
  localparam logic [10:0] HC_L  = 11'(Hc);
  localparam logic [11:0] HD_L  = 12'(Hd);
  localparam logic [10:0] VA_L  = 11'(Va);
  localparam logic [10:0] VB_L  = 11'(Vb);
  localparam logic [10:0] VC_L  = 11'(Vc);
  localparam logic [11:0] VD_L  = 12'(Vd);
  localparam logic [7:0]  LCK_L = 8'(LOCK_FRAMES);
  localparam logic [7:0]  ULK_L = 8'(UNLOCK_FRAMES);

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [10:0] hsw_q, hsw_d;
  logic [10:0] vsw_q, vsw_d;
  logic        vpend_q, vpend_d;
  logic        de_bad_q, de_bad_d;
  logic        lseen_q, lseen_d;
  logic        fseen_q, fseen_d;
  logic        fherr_q, fherr_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  bad_q, bad_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        pv_q, pv_d;
  logic        fs_q, fs_d;
  logic        lk_q, lk_d;
  logic        herr_q, herr_d;
  logic        verr_q, verr_d;
  logic [10:0] ht_q, ht_d, vt_q, vt_d;

  logic        hs_a, vs_a;
  logic        h_edge, h_fall;
  logic        v_edge, v_fall;
  logic        v_clr, sat, de_exp;
  logic        line_bad, frame_bad, frame_eval;
  logic [11:0] h_len, v_len;
  logic [10:0] h_inc, v_inc;
  logic [10:0] cur_h, cur_v;

  // Decode edges, counter values and line/frame verdicts for this sample
  always_comb begin
    hs_a   = (Hsync == SYNC_POL);
    vs_a   = (Vsync == SYNC_POL);
    h_edge = hs_a & ~hs_q;
    h_fall = ~hs_a & hs_q;
    v_edge = vs_a & ~vs_q;
    v_fall = ~vs_a & vs_q;
    h_len  = {1'b0, hcnt_q} + 12'd1;
    v_len  = {1'b0, vcnt_q} + 12'd1;
    h_inc  = h_len[11] ? CMAX : h_len[10:0];
    v_inc  = v_len[11] ? CMAX : v_len[10:0];
    v_clr  = h_edge & (vpend_q | v_edge);
    cur_h  = h_edge ? 11'd0 : h_inc;
    cur_v  = v_clr ? 11'd0 : (h_edge ? v_inc : vcnt_q);
    sat    = (cur_h == CMAX) | (cur_v == CMAX);
    de_exp = (cur_v >= VB_L) && (cur_v < VC_L) &&
             (cur_h >= HB_L) && (cur_h < HC_L);
    line_bad = h_edge & lseen_q &
               ((h_len != HD_L) | (hsw_q != HA_L) | de_bad_q);
    frame_bad = (v_len != VD_L) | (vsw_q != VA_L) |
                fherr_q | line_bad;
    frame_eval = v_clr & fseen_q;
  end

  // Next-state for counters, checkers, lock FSM and outputs
  always_comb begin
    state_d  = state_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    hsw_d    = hsw_q;
    vsw_d    = vsw_q;
    vpend_d  = vpend_q;
    de_bad_d = de_bad_q;
    lseen_d  = lseen_q;
    fseen_d  = fseen_q;
    fherr_d  = fherr_q;
    good_d   = good_q;
    bad_d    = bad_q;
    x_d      = x_q;
    y_d      = y_q;
    pv_d     = pv_q;
    lk_d     = lk_q;
    ht_d     = ht_q;
    vt_d     = vt_q;
    fs_d     = 1'b0;
    herr_d   = 1'b0;
    verr_d   = 1'b0;
    if (pix_en) begin
      hs_d    = hs_a;
      vs_d    = vs_a;
      hcnt_d  = cur_h;
      vcnt_d  = cur_v;
      vpend_d = v_clr ? 1'b0 : (v_edge | vpend_q);
      hsw_d   = h_edge ? 11'd0 : (h_fall ? cur_h : hsw_q);
      vsw_d   = v_fall ? cur_v : (v_clr ? 11'd0 : vsw_q);
      de_bad_d = h_edge ? (dena != de_exp)
                        : (de_bad_q | (dena != de_exp));
      lseen_d = lseen_q | h_edge;
      fseen_d = fseen_q | v_clr;
      fherr_d = v_clr ? 1'b0 : (fherr_q | line_bad);
      if (h_edge) ht_d = h_inc;
      if (v_clr)  vt_d = v_inc;
      herr_d = line_bad;
      verr_d = frame_eval & frame_bad;
      fs_d   = v_edge;
      if (sat) begin
        state_d = SEARCH;
        good_d  = 8'd0;
        bad_d   = 8'd0;
      end else begin
        unique case (state_q)
          SEARCH: begin
            if (v_edge) begin
              state_d = ACQUIRE;
              good_d  = 8'd0;
              bad_d   = 8'd0;
            end
          end
          ACQUIRE: begin
            if (frame_eval) begin
              if (frame_bad) begin
                good_d = 8'd0;
              end else if (good_q + 8'd1 >= LCK_L) begin
                state_d = LOCKED;
                good_d  = 8'd0;
                bad_d   = 8'd0;
              end else begin
                good_d = good_q + 8'd1;
              end
            end
          end
          LOCKED: begin
            if (frame_eval) begin
              if (!frame_bad) begin
                bad_d = 8'd0;
              end else if (bad_q + 8'd1 >= ULK_L) begin
                state_d = SEARCH;
                bad_d   = 8'd0;
              end else begin
                bad_d = bad_q + 8'd1;
              end
            end
          end
          default: state_d = SEARCH;
        endcase
      end
      lk_d = (state_d == LOCKED);
      pv_d = dena & lk_d;
      if (pv_d) begin
        x_d = 10'(cur_h - HB_L);
        y_d = 10'(cur_v - VB_L);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hsw_q    <= '0;
      vsw_q    <= '0;
      vpend_q  <= 1'b0;
      de_bad_q <= 1'b0;
      lseen_q  <= 1'b0;
      fseen_q  <= 1'b0;
      fherr_q  <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
      lk_q     <= 1'b0;
      herr_q   <= 1'b0;
      verr_q   <= 1'b0;
      ht_q     <= '0;
      vt_q     <= '0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hsw_q    <= hsw_d;
      vsw_q    <= vsw_d;
      vpend_q  <= vpend_d;
      de_bad_q <= de_bad_d;
      lseen_q  <= lseen_d;
      fseen_q  <= fseen_d;
      fherr_q  <= fherr_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pv_q     <= pv_d;
      fs_q     <= fs_d;
      lk_q     <= lk_d;
      herr_q   <= herr_d;
      verr_q   <= verr_d;
      ht_q     <= ht_d;
      vt_q     <= vt_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign locked      = lk_q;
  assign h_err       = herr_q;
  assign v_err       = verr_q;
  assign h_total     = ht_q;
  assign v_total     = vt_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: drives small-geometry VGA frames with random
// strobe spacing and checks against a frame-level reference model.
module tb_vga_timing_monitor;

  localparam int HA = 4;
  localparam int HB = 8;
  localparam int HC = 24;
  localparam int HD = 28;
  localparam int VA = 2;
  localparam int VB = 4;
  localparam int VC = 10;
  localparam int VD = 12;
  localparam int LOCKF = 2;
  localparam int UNLOCKF = 2;
  localparam int NPIX = (HC - HB) * (VC - VB);

  logic        clk = 1'b0;
  logic        reset, pix_en, Hsync, Vsync, dena;
  logic [9:0]  x, y;
  logic        pixel_valid, frame_start, locked;
  logic        h_err, v_err;
  logic [10:0] h_total, v_total;

  int total = 0;
  int bad = 0;
  bit rnd_gap = 0;

  int st = 0;
  int good_n = 0;
  int bad_n = 0;
  bit have_line = 0;
  bit have_frame = 0;
  bit prev_line_bad = 0;
  bit fr_herr = 0;
  int prev_len = 0;
  int fr_lines = 0;
  int fr_vsw = 0;
  int last_c = 0;

  vga_timing_monitor #(
    .Ha(HA), .Hb(HB), .Hc(HC), .Hd(HD),
    .Va(VA), .Vb(VB), .Vc(VC), .Vd(VD),
    .SYNC_POL(1'b0),
    .LOCK_FRAMES(LOCKF), .UNLOCK_FRAMES(UNLOCKF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .Hsync(Hsync),
    .Vsync(Vsync),
    .dena(dena),
    .x(x),
    .y(y),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .locked(locked),
    .h_err(h_err),
    .v_err(v_err),
    .h_total(h_total),
    .v_total(v_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic hs, input logic vs,
                        input logic de);
    int g;
    g = rnd_gap ? int'($urandom_range(2, 0)) : 1;
    for (int i = 0; i < g; i++) begin
      pix_en = 1'b0;
      @(posedge clk);
      #1;
      chk("gap_h_err", h_err, 0);
      chk("gap_v_err", v_err, 0);
      chk("gap_frame_start", frame_start, 0);
    end
    pix_en = 1'b1;
    Hsync  = hs;
    Vsync  = vs;
    dena   = de;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
  endtask

  task automatic lock_step(input bit fb);
    if (st == 0) begin
      st = 1;
      good_n = 0;
    end else if (have_frame) begin
      if (st == 1) begin
        if (fb) good_n = 0;
        else begin
          good_n++;
          if (good_n == LOCKF) begin
            st = 2;
            bad_n = 0;
          end
        end
      end else begin
        if (fb) begin
          bad_n++;
          if (bad_n == UNLOCKF) begin
            st = 0;
            bad_n = 0;
          end
        end else bad_n = 0;
      end
    end
  endtask

  task automatic send_frame(input int vsw, input int short_l,
                            input int nlines);
    int len, cnt;
    bit eh, fb, de, full_lock, pv;
    cnt = 0;
    full_lock = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_l) ? HD - 1 : HD;
      for (int c = 0; c < len; c++) begin
        de = (l >= VB) && (l < VC) && (c >= HB) && (c < HC);
        strobe(c >= HA, l >= vsw, de);
        if (l == 0 && c == 0) begin
          eh = have_line && prev_line_bad;
          fb = (fr_lines != VD) || (fr_vsw != VA) || fr_herr || eh;
          chk("frame_start", frame_start, 1);
          chk("h_err_fend", h_err, eh);
          chk("v_err", v_err, have_frame && fb);
          if (have_frame) chk("v_total", v_total, fr_lines);
          if (have_line && prev_len > 0)
            chk("h_total_f", h_total, prev_len);
          lock_step(fb);
          have_line = 1;
          have_frame = 1;
          fr_lines = 0;
          fr_vsw = vsw;
          fr_herr = 0;
          full_lock = (st == 2);
        end else if (c == 0) begin
          eh = prev_line_bad;
          fr_herr = fr_herr | eh;
          chk("h_err_line", h_err, eh);
          chk("v_err_line", v_err, 0);
          chk("frame_start_line", frame_start, 0);
          if (prev_len > 0) chk("h_total", h_total, prev_len);
        end else begin
          chk("h_err_mid", h_err, 0);
          chk("v_err_mid", v_err, 0);
          chk("frame_start_mid", frame_start, 0);
        end
        pv = de && (st == 2);
        chk("locked", locked, st == 2);
        chk("pixel_valid", pixel_valid, pv);
        if (pv) begin
          chk("x", x, c - HB);
          chk("y", y, l - VB);
        end
        if (pixel_valid === 1'b1) cnt++;
      end
      prev_line_bad = (len != HD);
      prev_len = len;
      fr_lines++;
      last_c = len - 1;
    end
    if (nlines == VD && full_lock && st == 2)
      chk("valid_count", cnt, NPIX);
  endtask

  task automatic hold_sync(input int n);
    for (int i = 1; i <= n; i++) begin
      strobe(1'b1, 1'b1, 1'b0);
      if (last_c + i >= 2047) begin
        st = 0;
        good_n = 0;
        bad_n = 0;
      end
      chk("hold_locked", locked, st == 2);
      chk("hold_h_err", h_err, 0);
      chk("hold_pv", pixel_valid, 0);
    end
    prev_line_bad = 1;
    prev_len = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_pv", pixel_valid, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_locked", locked, 0);
    chk("rst_h_err", h_err, 0);
    chk("rst_v_err", v_err, 0);
    chk("rst_h_total", h_total, 0);
    chk("rst_v_total", v_total, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    st = 0;
    good_n = 0;
    bad_n = 0;
    have_line = 0;
    have_frame = 0;
    prev_line_bad = 0;
    prev_len = 0;
    fr_lines = 0;
    fr_vsw = 0;
    fr_herr = 0;
  endtask

  initial begin
    reset  = 1'b0;
    pix_en = 1'b0;
    Hsync  = 1'b1;
    Vsync  = 1'b1;
    dena   = 1'b0;
    do_reset();
    rnd_gap = 0;
    repeat (4) send_frame(VA, -1, VD);
    rnd_gap = 1;
    send_frame(VA, 5, VD);
    send_frame(VA, -1, VD);
    send_frame(3, -1, VD);
    send_frame(3, -1, VD);
    repeat (4) send_frame(VA, -1, VD);
    hold_sync(2100);
    send_frame(VA, -1, VD);
    send_frame(VA, -1, VD);
    send_frame(VA, -1, 6);
    do_reset();
    send_frame(VA, -1, VD);
    send_frame(VA, -1, VD);
    send_frame(VA, -1, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
